// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, column count and keymap
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Index of the lowest active-low bit; lowest index wins on ties.
  function automatic logic [1:0] low_idx(
    input logic [NUM_COLS-1:0] v
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: accepted-key bus from the scanner to the
// two-digit seven-segment multiplexer.
interface keypad_scanner_if;

  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_valid;

  modport master (
    output digit_new,
    output digit_old,
    output key_valid
  );

  modport slave (
    input digit_new,
    input digit_old,
    input key_valid
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-ones, the idle (no key) row pattern.
module sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, press/release debounce
// and two-digit history of accepted keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              rows,
  output logic [3:0]              cols,
  keypad_scanner_if.master        disp
);

  localparam int SW = (SCAN_DIV > 1) ?
                      $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    srows;
  logic [3:0]    latch_q;
  logic [SW-1:0] scan_q;
  logic [DW-1:0] deb_q;
  logic [3:0]    dnew_q;
  logic [3:0]    dold_q;
  logic          kv_q;

  logic any_low;
  logic match;
  logic scan_end;
  logic deb_end;

  logic col_adv;
  logic scan_clr;
  logic scan_inc;
  logic deb_clr;
  logic deb_inc;
  logic grab;
  logic accept;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (srows)
  );

  assign any_low  = (srows != 4'hF);
  assign match    = (srows == latch_q);
  assign scan_end = (scan_q == SW'(SCAN_DIV - 1));
  assign deb_end  = (deb_q == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SCAN:
        if (any_low) state_nx = DEBOUNCE;
      DEBOUNCE:
        if (!match)       state_nx = SCAN;
        else if (deb_end) state_nx = HELD;
      HELD:
        if (!any_low) state_nx = RELEASE;
      RELEASE:
        if (any_low)      state_nx = HELD;
        else if (deb_end) state_nx = SCAN;
      default:
        state_nx = SCAN;
    endcase
  end

  always_comb begin
    col_adv  = 1'b0;
    scan_clr = 1'b0;
    scan_inc = 1'b0;
    deb_clr  = 1'b0;
    deb_inc  = 1'b0;
    grab     = 1'b0;
    accept   = 1'b0;
    unique case (state)
      SCAN:
        if (any_low) begin
          grab    = 1'b1;
          deb_clr = 1'b1;
        end else if (scan_end) begin
          col_adv  = 1'b1;
          scan_clr = 1'b1;
        end else begin
          scan_inc = 1'b1;
        end
      DEBOUNCE:
        if (!match)       scan_clr = 1'b1;
        else if (deb_end) accept   = 1'b1;
        else              deb_inc  = 1'b1;
      HELD:
        if (!any_low) deb_clr = 1'b1;
      RELEASE:
        if (!any_low) begin
          if (deb_end) begin
            col_adv  = 1'b1;
            scan_clr = 1'b1;
          end else begin
            deb_inc = 1'b1;
          end
        end
      default: ;
    endcase
  end

  // Counters stop at their terminal count instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols    <= 4'b1110;
      scan_q  <= '0;
      deb_q   <= '0;
      latch_q <= 4'hF;
      dnew_q  <= 4'h0;
      dold_q  <= 4'h0;
      kv_q    <= 1'b0;
    end else begin
      if (col_adv)
        cols <= {cols[2:0], cols[3]};
      if (scan_clr)
        scan_q <= '0;
      else if (scan_inc && !scan_end)
        scan_q <= scan_q + SW'(1);
      if (deb_clr)
        deb_q <= '0;
      else if (deb_inc && !deb_end)
        deb_q <= deb_q + DW'(1);
      if (grab)
        latch_q <= srows;
      kv_q <= accept;
      if (accept) begin
        dold_q <= dnew_q;
        dnew_q <= key_code(low_idx(latch_q),
                           low_idx(cols));
      end
    end
  end

  assign disp.digit_new = dnew_q;
  assign disp.digit_old = dold_q;
  assign disp.key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random keypad activity against a behavioural
// keypad/scanner model, plus directed literal checks.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys  = '0;

  keypad_scanner_if dif ();

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows),
    .cols  (cols),
    .disp  (dif.master)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its
  // column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  logic [3:0] ctab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum {M_SCAN, M_DEB, M_HELD, M_REL} mph_t;

  mph_t       ph     = M_SCAN;
  int         mcol   = 0;
  int         msc    = 0;
  int         mrun   = 0;
  logic [3:0] mlatch = 4'hF;
  logic [3:0] m1     = 4'hF;
  logic [3:0] m2     = 4'hF;
  logic [3:0] mnew   = 4'h0;
  logic [3:0] mold   = 4'h0;
  logic       mkv    = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = M_SCAN; mcol = 0; msc = 0; mrun = 0;
      mlatch = 4'hF; m1 = 4'hF; m2 = 4'hF;
      mnew = 4'h0; mold = 4'h0; mkv = 1'b0;
    end else begin
      int r;
      mkv = 1'b0;
      case (ph)
        M_SCAN:
          if (m2 != 4'hF) begin
            mlatch = m2; mrun = 1; ph = M_DEB;
          end else begin
            msc++;
            if (msc == SD) begin
              msc = 0; mcol = (mcol + 1) % 4;
            end
          end
        M_DEB:
          if (m2 != mlatch) begin
            ph = M_SCAN; msc = 0;
          end else if (mrun == DB) begin
            r = 0;
            while (mlatch[r]) r++;
            mold = mnew;
            mnew = kmap[r*4+mcol];
            mkv  = 1'b1;
            ph   = M_HELD;
          end else begin
            mrun++;
          end
        M_HELD:
          if (m2 == 4'hF) begin
            mrun = 1; ph = M_REL;
          end
        M_REL:
          if (m2 != 4'hF) begin
            ph = M_HELD;
          end else if (mrun == DB) begin
            ph = M_SCAN; msc = 0; mcol = (mcol + 1) % 4;
          end else begin
            mrun++;
          end
      endcase
      m2 = m1;
      m1 = rows;
    end
  end

  int vec    = 0;
  int bad    = 0;
  int pulses = 0;
  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (dif.key_valid === 1'b1) pulses++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [3:0] ec;
      ec = ctab[mcol];
      vec++;
      if (cols !== ec || dif.digit_new !== mnew ||
          dif.digit_old !== mold || dif.key_valid !== mkv) begin
        bad++;
        $display("FAIL model t=%0t cols=%b/%b new=%h/%h old=%h/%h kv=%b/%b",
                 $time, cols, ec, dif.digit_new, mnew,
                 dif.digit_old, mold, dif.key_valid, mkv);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_kv(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (dif.key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic press_accept(input int k, input logic [3:0] en,
                              input logic [3:0] eo, input string nm);
    bit ok;
    keys = 16'(1) << k;
    wait_kv(80, ok);
    chk({nm, " accepted"}, 32'(ok), 1);
    chk({nm, " new"}, dif.digit_new, en);
    chk({nm, " old"}, dif.digit_old, eo);
    cyc(20);
    keys = '0;
    cyc(30);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int p0;
    int n;
    #1 reset = 1'b0;
    #1;
    chk("reset cols", cols, 4'b1110);
    chk("reset new", dif.digit_new, 0);
    chk("reset old", dif.digit_old, 0);
    chk("reset kv", dif.key_valid, 0);
    chk_on = 1'b1;
    cyc(3);
    reset = 1'b1;
    chk("idle cols k0", cols, ctab[0]);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("idle cols k%0d", k), cols, ctab[(k/4)%4]);
    end
    chk("idle no kv", pulses, 0);

    press_accept(6, 4'h6, 4'h0, "r1c2");
    press_accept(13, 4'h0, 4'h6, "r3c1");
    press_accept(3, 4'hA, 4'h0, "r0c3");
    chk("three presses", pulses, 3);

    // Short press while its column is being driven.
    p0 = pulses;
    n = 0;
    while (cols !== 4'b1101 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("short col seen", 32'(cols), 4'b1101);
    keys = 16'(1) << 5;
    cyc(5);
    keys = '0;
    cyc(30);
    chk("short no kv", pulses, p0);
    n = 0;
    begin
      logic [3:0] c0;
      c0 = cols;
      while (cols === c0 && n < 20) begin
        @(negedge clk); n++;
      end
      chk("short scan resumes", 32'(n < 20), 1);
    end

    // Long hold with release glitches.
    p0 = pulses;
    keys = 16'(1) << 8;
    wait_kv(80, ok);
    chk("glitch accepted", 32'(ok), 1);
    chk("glitch new", dif.digit_new, 4'h7);
    chk("glitch old", dif.digit_old, 4'hA);
    for (int g = 0; g < 4; g++) begin
      cyc(15);
      keys = '0;
      cyc(3);
      keys = 16'(1) << 8;
      cyc(4);
      chk($sformatf("glitch frozen %0d", g), cols, 4'b1110);
    end
    cyc(5);
    keys = '0;
    n = 0;
    while (cols === 4'b1110 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("release latency", n, 11);
    chk("glitch one kv", pulses - p0, 1);

    // Reset in the middle of debounce.
    p0 = pulses;
    keys = 16'(1) << 1;
    n = 0;
    while (ph != M_DEB && n < 40) begin
      @(negedge clk); n++;
    end
    chk("reached debounce", 32'(ph == M_DEB), 1);
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk("async cols", cols, 4'b1110);
    chk("async new", dif.digit_new, 0);
    chk("async old", dif.digit_old, 0);
    chk("async kv", dif.key_valid, 0);
    keys = '0;
    cyc(3);
    reset = 1'b1;
    chk("post reset cols", cols, 4'b1110);
    cyc(30);
    chk("post reset no kv", pulses, p0);

    // Random keypad activity, model-checked every cycle.
    for (int e = 0; e < 40; e++) begin
      int k;
      int hold;
      logic [15:0] pat;
      k = int'($urandom_range(0, 15));
      pat = 16'(1) << k;
      if ($urandom_range(0, 3) == 0)
        pat = pat | (16'(1) << $urandom_range(0, 15));
      hold = ($urandom_range(0, 1) == 1) ?
             int'($urandom_range(2, 7)) :
             int'($urandom_range(20, 70));
      keys = pat;
      cyc(hold);
      if ($urandom_range(0, 2) == 0) begin
        keys = '0;
        cyc(int'($urandom_range(1, 4)));
        keys = pat;
        cyc(10);
      end
      keys = '0;
      cyc(int'($urandom_range(0, 30)));
    end
    cyc(20);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameters SHALL be as follows, one per line:
  SCAN_DIV  24000  clock cycles each column is driven before advancing (1 ms at 24 MHz)
  DEBOUNCE_CYCLES  480000  consecutive stable cycles needed to accept a press or release (20 ms)
REQ-002 Ports SHALL be as follows, one per line:
  clk  in  1  system clock (on-chip oscillator)
  reset  in  1  asynchronous, active-low reset
  rows  in  4  keypad row sense, active-low (pulled up), asynchronous to clk
  cols  out  4  column drive, active-low one-hot
  digit_new  out  4  hex code of the most recently accepted key
  digit_old  out  4  hex code of the key accepted before digit_new
  key_valid  out  1  one-cycle pulse when a key is accepted
REQ-003 There SHALL be one clock, clk; reset SHALL be asynchronous and active-low, named reset.
REQ-004 digit_new and digit_old SHALL feed the downstream two-digit seven-segment multiplexer directly as its two 4-bit digit inputs.

Function
REQ-005 rows SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (srows), 2 cycles of input latency.
REQ-006 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-007 SCAN: cols SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, dwelling SCAN_DIV cycles per column.
REQ-008 SCAN: if any srows bit is 0, the column SHALL freeze, srows SHALL be latched, the debounce counter SHALL clear, and the FSM SHALL enter DEBOUNCE.
REQ-009 DEBOUNCE: if srows differs from the latched pattern, the FSM SHALL return to SCAN and resume rotation from the frozen column with no output change.
REQ-010 DEBOUNCE: after DEBOUNCE_CYCLES consecutive matching cycles, the FSM SHALL enter HELD.
REQ-011 On that transition: key_valid SHALL be 1 for exactly one cycle, digit_old SHALL take digit_new, and digit_new SHALL take the decoded key, all in the same cycle.
REQ-012 If several rows are low, the lowest-index low row SHALL be decoded.
REQ-013 The keymap SHALL be (row, col 0..3):
  row0: 1 2 3 A
  row1: 4 5 6 B
  row2: 7 8 9 C
  row3: E 0 F D
REQ-014 HELD: cols SHALL stay frozen; any other key pressed SHALL be ignored; when srows = 1111 the counter SHALL clear and the FSM SHALL enter RELEASE.
REQ-015 RELEASE: any srows bit 0 SHALL return the FSM to HELD (bounce); DEBOUNCE_CYCLES consecutive cycles of 1111 SHALL return it to SCAN at the next column.
REQ-016 A held key SHALL produce exactly one key_valid, regardless of hold duration.
REQ-017 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate rather than wrap.
REQ-018 Outputs SHALL be registered; cols SHALL never have more than one bit low.

Reset
REQ-019 While reset = 0: state = SCAN, cols = 1110, digit_new = digit_old = 0000, key_valid = 0, counters = 0, synchronizer = 1111.
REQ-020 Reset asserted mid-press or mid-debounce SHALL discard the press; after release the FSM SHALL restart scanning at column 0.

Structure
REQ-021 The package keypad_pkg SHALL hold the state enum, the keymap table or function, and the column-count constant (4).
REQ-022 The synchronizer SHALL be a sub-module named sync_2ff (4 bits wide, with reset).

Verification (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8)
REQ-023 Idle after reset -> cols cycles 1110, 1101, 1011, 0111 at 4 cycles each; key_valid stays 0.
REQ-024 rows = 1101 held while cols = 1011 (row1, col2) -> key_valid pulses once; digit_new = 6, digit_old = 0.
REQ-025 Then key row3/col1 pressed and released -> digit_new = 0, digit_old = 6; a further press of row0/col3 -> digit_new = A, digit_old = 0.
REQ-026 Press lasting 5 cycles (less than DEBOUNCE_CYCLES) -> no key_valid; scanning resumes.
REQ-027 Key held for 100 cycles with 3-cycle release glitches -> exactly one key_valid; no SCAN until 8 clean release cycles.
REQ-028 reset pulled low during DEBOUNCE -> all outputs match REQ-019 immediately (asynchronously); no key_valid after reset releases.
